config_port_arbiter: RTL and testbench

- Shares the single ConfigFSM write port between the configuration sources: self-write (CPU), bitbang, UART and the JTAG port, already synchronised to CLK.
- Replaces the static priority mux with session-locked arbitration. A source that wins keeps the port until it goes idle, so a higher-priority source cannot splice words into a running bitstream.
- Emits a one-cycle FSM_Reset on every ownership change and registers the forwarded data and strobe.

---
 rtl/config_port_arbiter_if.sv | 29 ++
 rtl/config_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_config_port_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/config_port_arbiter_if.sv
// Bus bundle between the configuration sources and the shared ConfigFSM write port.
// master = source/ConfigFSM side, slave = arbiter.
interface config_port_arbiter_if #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NUM_SRC-1:0]            src_active;
  logic [NUM_SRC-1:0]            src_strobe;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [DATA_WIDTH-1:0]         ConfigWriteData;
  logic                          ConfigWriteStrobe;
  logic                          FSM_Reset;
  logic [NUM_SRC-1:0]            owner_onehot;
  logic                          busy;
  logic                          dropped_strobe;
  logic [7:0]                    drop_count;

  modport master (
    output src_active, src_strobe, src_data,
    input  ConfigWriteData, ConfigWriteStrobe, FSM_Reset, owner_onehot, busy,
           dropped_strobe, drop_count
  );

  modport slave (
    input  src_active, src_strobe, src_data,
    output ConfigWriteData, ConfigWriteStrobe, FSM_Reset, owner_onehot, busy,
           dropped_strobe, drop_count
  );
endinterface

// File: rtl/config_port_arbiter.sv
// Session-locked arbiter for the ConfigFSM write port: the winning source keeps the port
// until it has been idle long enough, so no other source can splice words into its bitstream.
module config_port_arbiter #(
  parameter int unsigned NUM_SRC      = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input logic                  CLK,
  input logic                  resetn,
  config_port_arbiter_if.slave bus_io
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSwitch = 2'd1;
  localparam logic [1:0] StGrant  = 2'd2;
  localparam logic [1:0] StHold   = 2'd3;

  localparam logic [7:0] TimeoutLast = 8'(IDLE_TIMEOUT - 1);

  logic [1:0]            state_q, state_d;
  logic [NUM_SRC-1:0]    owner_q, owner_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wstrobe_q, wstrobe_d;
  logic                  fsm_reset_q, fsm_reset_d;
  logic                  dropped_q;
  logic [7:0]            drop_cnt_q, drop_cnt_d;
  logic [7:0]            idle_cnt_q, idle_cnt_d;

  logic [NUM_SRC-1:0]    req, win_oh, drop_mask;
  logic [DATA_WIDTH-1:0] win_data, own_data;
  logic                  own_strobe, own_req;

  // Highest index wins, so later loop iterations override earlier ones.
  always_comb begin
    req      = bus_io.src_active | bus_io.src_strobe;
    win_oh   = '0;
    win_data = '0;
    own_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_data  = bus_io.src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (owner_q[i]) begin
        own_data = bus_io.src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    own_strobe = |(bus_io.src_strobe & owner_q);
    own_req    = |(req & owner_q);
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    wdata_d      = wdata_q;
    wstrobe_d    = 1'b0;
    fsm_reset_d  = 1'b0;
    idle_cnt_d   = idle_cnt_q;
    drop_mask    = '0;

    case (state_q)
      StIdle: begin
        drop_mask = bus_io.src_strobe & ~win_oh;
        if (|req) begin
          state_d     = StSwitch;
          owner_d     = win_oh;
          fsm_reset_d = 1'b1;
          if (|(bus_io.src_strobe & win_oh)) begin
            pend_valid_d = 1'b1;
            pend_data_d  = win_data;
          end
        end
      end
      StSwitch: begin
        state_d   = StGrant;
        drop_mask = bus_io.src_strobe & ~owner_q;
        // The slot drains into the first GRANT cycle; a new owner word then has no room.
        if (pend_valid_q) begin
          wstrobe_d    = 1'b1;
          wdata_d      = pend_data_q;
          pend_valid_d = 1'b0;
          if (own_strobe) drop_mask = drop_mask | owner_q;
        end else if (own_strobe) begin
          wstrobe_d = 1'b1;
          wdata_d   = own_data;
        end
      end
      StGrant, StHold: begin
        drop_mask = bus_io.src_strobe & ~owner_q;
        if (own_strobe) begin
          wstrobe_d = 1'b1;
          wdata_d   = own_data;
        end
        if (state_q == StGrant) begin
          if (!own_req) begin
            state_d    = StHold;
            idle_cnt_d = 8'd0;
          end
        end else if (own_req) begin
          state_d = StGrant;
        end else if (idle_cnt_q == TimeoutLast) begin
          state_d = StIdle;
          owner_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    drop_cnt_d = ((|drop_mask) && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      wdata_q      <= '0;
      wstrobe_q    <= 1'b0;
      fsm_reset_q  <= 1'b0;
      dropped_q    <= 1'b0;
      drop_cnt_q   <= 8'd0;
      idle_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      wdata_q      <= wdata_d;
      wstrobe_q    <= wstrobe_d;
      fsm_reset_q  <= fsm_reset_d;
      dropped_q    <= |drop_mask;
      drop_cnt_q   <= drop_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end

  assign bus_io.ConfigWriteData   = wdata_q;
  assign bus_io.ConfigWriteStrobe = wstrobe_q;
  assign bus_io.FSM_Reset         = fsm_reset_q;
  assign bus_io.owner_onehot      = owner_q;
  assign bus_io.busy              = (state_q != StIdle);
  assign bus_io.dropped_strobe    = dropped_q;
  assign bus_io.drop_count        = drop_cnt_q;

endmodule

// File: tb/tb_config_port_arbiter.sv
// Directed and randomized bench for config_port_arbiter, checked every cycle against a
// session model that counts quiet cycles of the owner rather than tracking FSM states.
module tb_config_port_arbiter;
  localparam int unsigned NS = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic CLK = 1'b0;
  logic resetn = 1'b0;
  always #5 CLK = ~CLK;

  config_port_arbiter_if #(.NUM_SRC(NS), .DATA_WIDTH(DW)) bus ();

  config_port_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .IDLE_TIMEOUT(TO)) dut (
    .CLK    (CLK),
    .resetn (resetn),
    .bus_io (bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: owner index (-1 = port free), first cycle after a grant, run of quiet owner cycles.
  int          m_owner;
  bit          m_switch;
  int          m_quiet;
  logic [31:0] m_pend[$];
  logic        m_wstb, m_fsm, m_drop;
  logic [31:0] m_data;
  int          m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_switch = 0; m_quiet = 0; m_pend.delete();
    m_wstb = 0; m_fsm = 0; m_drop = 0; m_data = '0; m_cnt = 0;
  endtask

  task automatic model_step();
    logic [NS-1:0] stb, req;
    logic [31:0]   d[NS];
    int            k;
    bit            drop;
    stb  = bus.src_strobe;
    req  = bus.src_active | bus.src_strobe;
    for (int i = 0; i < NS; i++) d[i] = bus.src_data[i*DW +: DW];
    m_fsm = 0; m_wstb = 0; drop = 0;
    if (m_owner < 0) begin
      k = -1;
      for (int i = 0; i < NS; i++) if (req[i]) k = i;
      if (k >= 0) begin
        m_owner = k; m_fsm = 1; m_switch = 1;
        if (stb[k]) m_pend.push_back(d[k]);
      end
      for (int i = 0; i < NS; i++) if (stb[i] && i != k) drop = 1;
    end else begin
      k = m_owner;
      for (int i = 0; i < NS; i++) if (stb[i] && i != k) drop = 1;
      if (m_switch) begin
        m_switch = 0; m_quiet = 0;
        if (m_pend.size() > 0) begin
          m_wstb = 1; m_data = m_pend.pop_front();
          if (stb[k]) drop = 1;
        end else if (stb[k]) begin
          m_wstb = 1; m_data = d[k];
        end
      end else begin
        if (stb[k]) begin m_wstb = 1; m_data = d[k]; end
        if (req[k]) m_quiet = 0;
        else begin
          m_quiet++;
          // One quiet GRANT cycle plus TO quiet HOLD cycles releases the port.
          if (m_quiet == TO + 1) m_owner = -1;
        end
      end
    end
    m_drop = drop;
    if (drop && m_cnt < 255) m_cnt++;
  endtask

  task automatic check_all();
    chk("wstrobe", 64'(bus.ConfigWriteStrobe), 64'(m_wstb));
    chk("wdata", 64'(bus.ConfigWriteData), 64'(m_data));
    chk("fsm_reset", 64'(bus.FSM_Reset), 64'(m_fsm));
    chk("owner", 64'(bus.owner_onehot), (m_owner < 0) ? 64'd0 : 64'(1) << m_owner);
    chk("busy", 64'(bus.busy), 64'(m_owner >= 0));
    chk("dropped", 64'(bus.dropped_strobe), 64'(m_drop));
    chk("drop_count", 64'(bus.drop_count), 64'(m_cnt));
  endtask

  task automatic step();
    @(posedge CLK);
    if (resetn) model_step();
    #1;
    check_all();
  endtask

  task automatic set_data(input int i, input logic [31:0] d);
    bus.src_data[i*DW +: DW] = d;
  endtask

  initial begin
    bus.src_active = '0; bus.src_strobe = '0; bus.src_data = '0;
    model_reset();
    // Reset then idle
    repeat (3) @(posedge CLK);
    #1;
    check_all();
    resetn = 1'b1;
    repeat (20) step();

    // Single UART session
    bus.src_active[2] = 1'b1;
    step();
    chk("uart_fsm_reset", 64'(bus.FSM_Reset), 64'd1);
    step();
    chk("uart_fsm_reset_once", 64'(bus.FSM_Reset), 64'd0);
    bus.src_strobe[2] = 1'b1; set_data(2, 32'hA5A5A5A5); step();
    chk("uart_w0", 64'(bus.ConfigWriteData), 64'hA5A5A5A5);
    set_data(2, 32'h00000001); step();
    chk("uart_w1", 64'(bus.ConfigWriteData), 64'h1);
    bus.src_strobe[2] = 1'b0;
    repeat (6) step();
    bus.src_strobe[2] = 1'b1; set_data(2, 32'hDEADBEEF); step();
    chk("uart_w2_stb", 64'(bus.ConfigWriteStrobe), 64'd1);
    chk("uart_w2", 64'(bus.ConfigWriteData), 64'hDEADBEEF);
    chk("uart_owner", 64'(bus.owner_onehot), 64'b0100);
    bus.src_strobe[2] = 1'b0; bus.src_active[2] = 1'b0;
    repeat (TO + 4) step();
    chk("uart_released", 64'(bus.busy), 64'd0);

    // Strobe-initiated grant with pending slot
    bus.src_strobe[0] = 1'b1; set_data(0, 32'h12345678); step();
    chk("pend_fsm_reset", 64'(bus.FSM_Reset), 64'd1);
    bus.src_strobe[0] = 1'b0; step();
    chk("pend_stb", 64'(bus.ConfigWriteStrobe), 64'd1);
    chk("pend_data", 64'(bus.ConfigWriteData), 64'h12345678);
    repeat (TO) step();
    chk("pend_still_busy", 64'(bus.busy), 64'd1);
    step();
    chk("pend_idle", 64'(bus.busy), 64'd0);

    // Simultaneous requests: JTAG wins, bitbang strobes are dropped
    bus.src_active[1] = 1'b1; bus.src_active[3] = 1'b1; step();
    chk("sim_owner", 64'(bus.owner_onehot), 64'b1000);
    step();
    for (int n = 0; n < 3; n++) begin
      bus.src_strobe[1] = 1'b1; set_data(1, 32'hBAD0BAD0 + 32'(n)); step();
      chk("sim_dropped", 64'(bus.dropped_strobe), 64'd1);
      chk("sim_no_fwd", 64'(bus.ConfigWriteStrobe), 64'd0);
      bus.src_strobe[1] = 1'b0; step();
    end
    chk("sim_drop_count", 64'(bus.drop_count), 64'd3);
    bus.src_active = '0;
    repeat (TO + 3) step();

    // Hold re-entry exactly at the last HOLD cycle
    bus.src_active[2] = 1'b1;
    repeat (3) step();
    bus.src_active[2] = 1'b0;
    step();
    repeat (TO - 1) step();
    bus.src_active[2] = 1'b1; step();
    chk("reentry_busy", 64'(bus.busy), 64'd1);
    chk("reentry_no_reset", 64'(bus.FSM_Reset), 64'd0);
    step();
    // One cycle later: the port is released and a fresh grant pulses FSM_Reset
    bus.src_active[2] = 1'b0;
    step();
    repeat (TO) step();
    chk("late_idle", 64'(bus.busy), 64'd0);
    bus.src_active[2] = 1'b1; step();
    chk("late_fsm_reset", 64'(bus.FSM_Reset), 64'd1);
    repeat (2) step();

    // Mid-session reset with a strobe in flight
    bus.src_strobe[2] = 1'b1; set_data(2, 32'hCAFEF00D);
    @(posedge CLK);
    model_step();
    #1;
    check_all();
    #1;
    resetn = 1'b0;
    #1;
    chk("rst_wstb", 64'(bus.ConfigWriteStrobe), 64'd0);
    chk("rst_wdata", 64'(bus.ConfigWriteData), 64'd0);
    chk("rst_owner", 64'(bus.owner_onehot), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_drop_count", 64'(bus.drop_count), 64'd0);
    bus.src_strobe = '0; bus.src_active = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    resetn = 1'b1;
    repeat (5) step();
    chk("post_rst_no_stb", 64'(bus.ConfigWriteStrobe), 64'd0);

    // Randomized traffic
    for (int c = 0; c < 700; c++) begin
      for (int i = 1; i < NS; i++) begin
        if ($urandom_range(15) == 0) bus.src_active[i] = ~bus.src_active[i];
      end
      for (int i = 0; i < NS; i++) begin
        bus.src_strobe[i] = ($urandom_range(3) == 0);
        set_data(i, $urandom);
      end
      step();
    end
    bus.src_active = '0; bus.src_strobe = '0;
    repeat (TO + 4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
